// File: rtl/sobel_column_buffer_if.sv
// FIFO-side signals of sobel_column_buffer: input pixel FIFO (FWFT) and output column FIFO.
// The master modport is the FIFO/environment side; the slave modport is the column buffer.
interface sobel_column_buffer_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
);
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    input  fifo_in_rd_en,
    output fifo_in_dout,
    output fifo_in_empty,
    input  fifo_out_wr_en,
    input  fifo_out_din,
    output fifo_out_full
  );

  modport slave (
    output fifo_in_rd_en,
    input  fifo_in_dout,
    input  fifo_in_empty,
    output fifo_out_wr_en,
    output fifo_out_din,
    input  fifo_out_full
  );
endinterface

// File: rtl/sobel_column_buffer.sv
// Turns a raster pixel stream into 3-pixel vertical columns {row y+2, y+1, y} using two line buffers.
// Optional macro SOBEL_COLBUF_BORDER_EN: also emit the first two rows with zero-padded missing rows.
module sobel_column_buffer #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  sobel_column_buffer_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic [DWIDTH_IN-1:0] lb0 [WIDTH];
  logic [DWIDTH_IN-1:0] lb1 [WIDTH];

  logic                  out_valid_q;
  logic [DWIDTH_OUT-1:0] out_data_q;

  logic [DWIDTH_IN-1:0]  pix, up1, up2;
  logic                  accept, write, col_end, frame_end, load;
  logic [DWIDTH_OUT-1:0] column;

  assign pix = bus.fifo_in_dout;
  assign up1 = lb1[col_q];
  assign up2 = lb0[col_q];

  assign col_end   = (col_q == COL_LAST);
  assign frame_end = col_end && (row_q == ROW_LAST);

  // A held column blocks input only while it cannot drain this cycle; reset masks both strobes.
  assign write  = reset & out_valid_q & ~bus.fifo_out_full;
  assign accept = reset & ~bus.fifo_in_empty & (~out_valid_q | ~bus.fifo_out_full);

  assign bus.fifo_in_rd_en  = accept;
  assign bus.fifo_out_wr_en = write;
  assign bus.fifo_out_din   = out_data_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    column  = '0;
    case (state_q)
      FILL: begin
        if (accept && col_end && (row_q == ROW_ONE)) state_d = RUN;
`ifdef SOBEL_COLBUF_BORDER_EN
        load = accept;
        if (row_q == '0) column = {pix, {DWIDTH_IN{1'b0}}, {DWIDTH_IN{1'b0}}};
        else             column = {pix, up1, {DWIDTH_IN{1'b0}}};
`endif
      end
      RUN: begin
        if (accept && frame_end) state_d = FILL;
        load   = accept;
        column = {pix, up1, up2};
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= frame_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // NOTE: line buffers are deliberately not reset; the two FILL rows overwrite them before any read is used.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb0[col_q] <= lb1[col_q];
      lb1[col_q] <= pix;
    end
  end

  // A write and a new load in the same cycle simply reload, keeping out_valid high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= column;
    end else if (write) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_column_buffer.sv
// Scoreboard bench for sobel_column_buffer at 4x4, pixel = 16*row + col; expected columns are hand-computed tables.
module tb_sobel_column_buffer;

  localparam int W = 4;
  localparam int H = 4;

`ifdef SOBEL_COLBUF_BORDER_EN
  localparam int WPF = 16;
  localparam int LAT = 1;
  localparam logic [23:0] EXP_TAB [WPF] = '{
    24'h000000, 24'h010000, 24'h020000, 24'h030000,
    24'h100000, 24'h110100, 24'h120200, 24'h130300,
    24'h201000, 24'h211101, 24'h221202, 24'h231303,
    24'h302010, 24'h312111, 24'h322212, 24'h332313
  };
`else
  localparam int WPF = 8;
  localparam int LAT = 9;
  localparam logic [23:0] EXP_TAB [WPF] = '{
    24'h201000, 24'h211101, 24'h221202, 24'h231303,
    24'h302010, 24'h312111, 24'h322212, 24'h332313
  };
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sobel_column_buffer_if #(.DWIDTH_IN(8), .DWIDTH_OUT(24)) bus ();

  sobel_column_buffer #(
    .WIDTH(W), .HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(24)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  int          wr_idx  = 0;
  bit          lat_chk = 1'b1;
  logic [23:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < WPF; i++) exp_q.push_back(EXP_TAB[i]);
  endtask

  // Present one pixel from a negedge, hold it until popped, return on the negedge after the pop.
  task automatic send(input logic [7:0] p, input bit gap);
    int n = 0;
    bus.fifo_in_dout  = p;
    bus.fifo_in_empty = 1'b0;
    #1;
    while (!bus.fifo_in_rd_en && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!bus.fifo_in_rd_en) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: pixel %h not read after %0d cycles", p, n);
    end
    @(negedge clock);
    acc_cnt++;
    if (gap) begin
      bus.fifo_in_empty = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < W * H; i++) send(8'(16 * (i / W) + (i % W)), gap);
  endtask

  task automatic drain(input string name, input int exp_writes);
    int n = 0;
    bus.fifo_in_empty = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_writes"}, wr_idx, exp_writes);
  endtask

  task automatic stall();
    wait (acc_cnt == 10);
    bus.fifo_out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_din", bus.fifo_out_din, 24'h211101);
      check("stall_rd_en", bus.fifo_in_rd_en, 0);
      check("stall_wr_en", bus.fifo_out_wr_en, 0);
      @(negedge clock);
    end
    bus.fifo_out_full = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every write, independent of the stimulus process.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (bus.fifo_in_empty) check("rd_en_while_empty", bus.fifo_in_rd_en, 0);
      if (bus.fifo_out_wr_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write", bus.fifo_out_din);
        end else begin
          e = exp_q.pop_front();
          check("column", bus.fifo_out_din, e);
        end
        if (lat_chk)
          check("write_after_accepts", acc_cnt, (wr_idx / WPF) * W * H + LAT + (wr_idx % WPF));
        wr_idx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b0;
    bus.fifo_in_dout   = 8'h55;
    bus.fifo_in_empty  = 1'b0;
    bus.fifo_out_full  = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("reset_rd_en", bus.fifo_in_rd_en, 0);
    check("reset_wr_en", bus.fifo_out_wr_en, 0);
    check("reset_din", bus.fifo_out_din, 0);
    @(negedge clock);
    reset             = 1'b1;
    bus.fifo_in_empty = 1'b1;
    #2;
    check("idle_din", bus.fifo_out_din, 0);
    check("idle_wr_en", bus.fifo_out_wr_en, 0);
    @(negedge clock);

    // Continuous frame
    acc_cnt = 0; wr_idx = 0;
    push_frame();
    send_frame(1'b0);
    drain("continuous", WPF);

    // Backpressure while 0x211101 is held
    acc_cnt = 0; wr_idx = 0; lat_chk = 1'b0;
    push_frame();
    fork
      send_frame(1'b0);
      stall();
    join
    drain("backpressure", WPF);
    lat_chk = 1'b1;

    // Input gaps every other cycle
    acc_cnt = 0; wr_idx = 0;
    push_frame();
    send_frame(1'b1);
    drain("gaps", WPF);

    // Back-to-back frames
    acc_cnt = 0; wr_idx = 0;
    push_frame();
    push_frame();
    send_frame(1'b0);
    send_frame(1'b0);
    drain("back_to_back", 2 * WPF);

    // Reset one cycle after pixel (2,1); its held column must be discarded
    acc_cnt = 0; wr_idx = 0;
    for (int i = 0; i < WPF - 7; i++) exp_q.push_back(EXP_TAB[i]);
    for (int i = 0; i < 10; i++) send(8'(16 * (i / W) + (i % W)), 1'b0);
    reset             = 1'b0;
    bus.fifo_in_dout  = 8'h00;
    bus.fifo_in_empty = 1'b0;
    #2;
    check("mid_reset_wr_en", bus.fifo_out_wr_en, 0);
    check("mid_reset_rd_en", bus.fifo_in_rd_en, 0);
    check("mid_reset_pre_writes", wr_idx, WPF - 7);
    @(negedge clock);
    reset             = 1'b1;
    bus.fifo_in_empty = 1'b1;
    #2;
    check("mid_reset_din", bus.fifo_out_din, 0);
    check("mid_reset_pending", exp_q.size(), 0);
    @(negedge clock);
    acc_cnt = 0; wr_idx = 0;
    push_frame();
    send_frame(1'b0);
    drain("after_reset", WPF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
